fir_avg_decim: RTL and testbench

- Downstream consumer of the 4-tap moving-sum FIR stage.
- Takes the FIR's registered W+2-bit sum every clock and converts it to a rounded average (sum/4).
- Discards the FIR pipeline warm-up, decimates by DECIM, and buffers results in a small FIFO behind a valid/ready output handshake.
- Provides a sticky overflow flag and a FIFO fill level for debug.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_avg_decim_sync_fifo.sv | 63 ++++++
 rtl/fir_avg_decim.sv | 82 ++++++++
 tb/tb_fir_avg_decim.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and the rounding helper for the FIR moving-sum stage
// and its averaging/decimating consumer.
package fir_pkg;

   localparam int FIR_WARMUP    = 5;
   localparam int FIR_TAPS_LOG2 = 2;
   localparam int AVG_MAX_W     = 32;

   // Round-half-up divide by the tap count, clamped to w bits.
   // Evaluated at a fixed wide width so any W up to AVG_MAX_W fits.
   function automatic logic [AVG_MAX_W-1:0] avg_round_sat(
      input logic [AVG_MAX_W+1:0] sum,
      input int                   w
   );
      logic [AVG_MAX_W+2:0] rounded;
      logic [AVG_MAX_W+2:0] limit;
      rounded = ({1'b0, sum} + (AVG_MAX_W+3)'(1 << (FIR_TAPS_LOG2 - 1))) >> FIR_TAPS_LOG2;
      limit   = ((AVG_MAX_W+3)'(1) << w) - (AVG_MAX_W+3)'(1);
      if (rounded > limit) begin
         rounded = limit;
      end
      return rounded[AVG_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/fir_avg_decim_sync_fifo.sv
// Small synchronous FIFO with a fall-through head: a write into an empty
// FIFO is visible on dout right after the write edge.
module sync_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          empty,
   output logic          full,
   output logic [LW-1:0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_reg;
   logic [AW-1:0] rd_reg;
   logic [LW-1:0] level_reg;
   logic          do_push;
   logic          do_pop;

   assign empty   = (level_reg == '0);
   assign full    = (level_reg == LW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push && !reset) begin
         mem[wr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_reg    <= '0;
         rd_reg    <= '0;
         level_reg <= '0;
      end else begin
         if (do_push) begin
            wr_reg <= wr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_reg <= rd_reg + AW'(1);
         end
         if (do_push && !do_pop) begin
            level_reg <= level_reg + LW'(1);
         end else if (do_pop && !do_push) begin
            level_reg <= level_reg - LW'(1);
         end
      end
   end

   assign dout  = mem[rd_reg];
   assign level = level_reg;

endmodule

// File: rtl/fir_avg_decim.sv
// Converts the FIR moving sum into a rounded average, skips the FIR warm-up,
// decimates by DECIM and queues results behind a valid/ready handshake.
module fir_avg_decim
   import fir_pkg::*;
#(
   parameter int W     = 16,
   parameter int DECIM = 4,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [W+1:0]           s_in,
   output logic [W-1:0]           m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow
);

   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int CW = $clog2(FIR_WARMUP + 1);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [CW-1:0] warm_reg;
   logic [PW-1:0] phase_reg;
   logic          overflow_reg;
   logic          warm_done;
   logic          take;
   logic          pop;
   logic          empty;
   logic          full;
   logic [W-1:0]  avg;
   logic [W-1:0]  head;

   assign warm_done = (warm_reg == CW'(FIR_WARMUP));
   assign take      = warm_done && (phase_reg == '0);
   assign pop       = ~empty & m_ready;
   assign avg       = W'(avg_round_sat((AVG_MAX_W+2)'(s_in), W));

   // Phase only runs once the warm-up counter has saturated, so the first
   // post-warm-up edge always lands on phase 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         warm_reg     <= '0;
         phase_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (!warm_done) begin
            warm_reg <= warm_reg + CW'(1);
         end else if (phase_reg == PW'(DECIM - 1)) begin
            phase_reg <= '0;
         end else begin
            phase_reg <= phase_reg + PW'(1);
         end
         if (take && full && !pop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .DW    (W),
      .DEPTH (DEPTH),
      .LW    (LW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (take),
      .din   (avg),
      .pop   (pop),
      .dout  (head),
      .empty (empty),
      .full  (full),
      .level (level)
   );

   // Storage is not cleared on reset; hide stale entries while empty.
   assign m_data   = empty ? '0 : head;
   assign m_valid  = ~empty;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_fir_avg_decim.sv
// Bench for fir_avg_decim: a DECIM=4 instance checked against a queue
// scoreboard and a DECIM=1 instance checked with direct rounding vectors.
module tb_fir_avg_decim;

   localparam int W      = 16;
   localparam int DEPTH  = 4;
   localparam int DECIM0 = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [17:0] s_in = '0;
   logic [17:0] s_in1 = '0;
   logic        m_ready = 1'b0;
   logic        m_ready1 = 1'b1;
   logic [15:0] m_data, m_data1;
   logic        m_valid, m_valid1;
   logic [2:0]  level, level1;
   logic        overflow, overflow1;

   always #5 clk = ~clk;

   fir_avg_decim #(.W(W), .DECIM(DECIM0), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .s_in(s_in), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .level(level), .overflow(overflow)
   );

   fir_avg_decim #(.W(W), .DECIM(1), .DEPTH(DEPTH)) dut1 (
      .clk(clk), .reset(reset), .s_in(s_in1), .m_data(m_data1), .m_valid(m_valid1),
      .m_ready(m_ready1), .level(level1), .overflow(overflow1)
   );

   typedef struct {
      logic [17:0] s;
      logic [15:0] expv;
   } rvec_t;

   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [15:0] exp_q[$];
   int          warm_m = 0;
   int          ph_m = 0;
   bit          ovf_m = 0;

   function automatic int avg_model(int s);
      int v;
      v = (s + 2) / 4;
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic chk(input string name, input int act, input int exp_v);
      vec_cnt++;
      if (act != exp_v) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   // One clock of the DECIM=4 instance: check current outputs, take the
   // edge, then advance the reference model. Starts and ends near negedge.
   task automatic step(input logic [17:0] s, input logic rdy, input string tag);
      bit pop_m;
      bit take_m;
      s_in = s;
      m_ready = rdy;
      #1;
      chk({tag, " level"}, int'(level), exp_q.size());
      chk({tag, " m_valid"}, int'(m_valid), (exp_q.size() != 0) ? 1 : 0);
      chk({tag, " overflow"}, int'(overflow), int'(ovf_m));
      if (exp_q.size() != 0) chk({tag, " m_data"}, int'(m_data), int'(exp_q[0]));
      @(posedge clk);
      pop_m  = (exp_q.size() != 0) && rdy;
      take_m = (warm_m == 5) && (ph_m == 0);
      if (pop_m) begin
         $display("xfer %s data=%0d level_before=%0d", tag, exp_q[0], exp_q.size());
         void'(exp_q.pop_front());
      end
      if (take_m) begin
         if (exp_q.size() == DEPTH) ovf_m = 1'b1;
         else exp_q.push_back(16'(avg_model(int'(s))));
      end
      if (warm_m < 5) warm_m++;
      else ph_m = (ph_m + 1) % DECIM0;
      @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      warm_m = 0;
      ph_m   = 0;
      ovf_m  = 1'b0;
      #1;
      chk("reset level", int'(level), 0);
      chk("reset m_valid", int'(m_valid), 0);
      chk("reset overflow", int'(overflow), 0);
      chk("reset m_data", int'(m_data), 0);
      chk("reset1 m_valid", int'(m_valid1), 0);
      chk("reset1 level", int'(level1), 0);
      chk("reset1 m_data", int'(m_data1), 0);
   endtask

   rvec_t tab[9];

   initial begin
      tab[0] = '{18'd5,       16'd1};
      tab[1] = '{18'd6,       16'd2};
      tab[2] = '{18'h3FFFC,   16'hFFFF};
      tab[3] = '{18'h3FFFF,   16'hFFFF};
      tab[4] = '{18'd4000,    16'd1000};
      tab[5] = '{18'd0,       16'd0};
      tab[6] = '{18'd1,       16'd0};
      tab[7] = '{18'd2,       16'd1};
      tab[8] = '{18'h3FFFD,   16'hFFFF};

      // Constant input on DECIM=4 while DECIM=1 sees a +4 ramp.
      do_reset(3);
      m_ready1 = 1'b1;
      for (int e = 0; e < 30; e++) begin
         s_in1 = 18'(4 * e);
         if (e >= 6) begin
            chk("decim1 m_valid", int'(m_valid1), 1);
            chk("decim1 m_data", int'(m_data1), e - 1);
         end else begin
            chk("decim1 warmup m_valid", int'(m_valid1), 0);
         end
         step(18'd4000, 1'b1, "const");
      end

      // Rounding and saturation vectors through the DECIM=1 instance.
      for (int i = 0; i < 9; i++) begin
         s_in1 = tab[i].s;
         step(18'd4000, 1'b1, "const");
         chk($sformatf("round[%0d] m_valid", i), int'(m_valid1), 1);
         chk($sformatf("round[%0d] m_data", i), int'(m_data1), int'(tab[i].expv));
      end

      // Backpressure: fill, drop the fifth sample, then drain in order.
      do_reset(1);
      for (int e = 0; e < 24; e++) step(18'(4 * (e + 1)), 1'b0, "bp");
      chk("bp full level", int'(level), 4);
      chk("bp overflow set", int'(overflow), 1);
      for (int e = 24; e < 42; e++) step(18'(4 * (e + 1)), 1'b1, "drain");
      chk("drain overflow sticky", int'(overflow), 1);

      // Full FIFO with push and pop on the same edge (edge 21 is a take edge).
      do_reset(1);
      for (int e = 0; e < 27; e++) begin
         step(18'(4 * (e + 1)), (e == 21 || e == 26), "fullpp");
         if (e == 21) begin
            chk("fullpp level", int'(level), 4);
            chk("fullpp overflow", int'(overflow), 0);
            chk("fullpp head", int'(m_data), 10);
         end
      end
      chk("pre-reset level", int'(level), 3);
      chk("pre-reset overflow", int'(overflow), 1);

      // Mid-stream reset discards everything and restarts warm-up.
      do_reset(1);
      for (int e = 0; e < 8; e++) step(18'd4000, 1'b1, "post");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
